// File: rtl/seg_monitor.sv
// seg_monitor: reconstructs a 4-digit hex value from a multiplexed 7-segment
// display scan. Each digit must hold stable for SETTLE cycles before it is
// captured. A full set of four digits publishes a new 16-bit value.
module seg_monitor #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segments,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        data_changed,
  output logic        err_seg,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;

  state_t      state;
  logic [3:0]  an_meta, an_sync;
  logic [6:0]  seg_meta, seg_sync;
  logic [10:0] held;
  logic [7:0]  cnt;
  logic [15:0] shadow, shadow_next;
  logic [3:0]  seen, seen_next;
  logic [10:0] sample;
  logic        one_hot, same, accept, cap_valid, cap_err, frame_done;
  logic [4:0]  dec;

  // Map a segment pattern to {valid, nibble}; unknown patterns are invalid.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous display inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_meta  <= '0;
      an_sync  <= '0;
      seg_meta <= '0;
      seg_sync <= '0;
    end else begin
      an_meta  <= anodes;
      an_sync  <= an_meta;
      seg_meta <= segments;
      seg_sync <= seg_meta;
    end
  end

  assign sample     = {an_sync, seg_sync};
  assign one_hot    = (an_sync != 4'b0) && ((an_sync & (an_sync - 4'd1)) == 4'b0);
  assign same       = (sample == held);
  assign dec        = decode(seg_sync);
  assign cap_valid  = accept && dec[4];
  assign cap_err    = accept && !dec[4];
  assign frame_done = (seen == 4'hF);
  assign seen_next  = seen | (cap_valid ? an_sync : 4'b0);

  // Decide whether the current synchronised sample completes a stable digit.
  always_comb begin
    accept = 1'b0;
    case (state)
      WAIT:    accept = one_hot && (SETTLE == 1);
      COUNT:   accept = one_hot && same && (({1'b0, cnt} + 9'd1) == 9'(SETTLE));
      default: accept = 1'b0;
    endcase
  end

  // Shadow value including any capture happening this cycle.
  always_comb begin
    shadow_next = shadow;
    for (int k = 0; k < 4; k++) begin
      if (cap_valid && an_sync[k]) shadow_next[4*k +: 4] = dec[3:0];
    end
  end

  // Stability FSM: wait for a one-hot digit, count stable cycles, then hold
  // until the digit changes so the same digit is not captured twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
      cnt   <= '0;
      held  <= '0;
    end else if (!one_hot) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      case (state)
        WAIT: begin
          held  <= sample;
          cnt   <= 8'd1;
          state <= (SETTLE == 1) ? HELD : COUNT;
        end
        COUNT: begin
          if (!same) begin
            state <= WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
            if (accept) state <= HELD;
          end
        end
        HELD: begin
          if (!same) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Collect captured nibbles and publish a frame once all four are seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow       <= '0;
      seen         <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      data_changed <= 1'b0;
    end else begin
      shadow       <= shadow_next;
      data_valid   <= frame_done;
      data_changed <= frame_done && (shadow_next != data_out);
      if (frame_done) begin
        data_out <= shadow_next;
        seen     <= '0;
      end else begin
        seen <= seen_next;
      end
    end
  end

  // Flag undecodable stable digits and keep a saturating tally of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_seg <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_seg <= cap_err;
      if (cap_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_seg_monitor.sv
// Testbench for seg_monitor: table-driven scans with a scoreboard of expected
// frames and error pulses, plus hand-written multi-cycle corner cases.
module tb_seg_monitor;

  logic        clk;
  logic        rst;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_changed;
  logic        err_seg;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    bit          frame;
    logic [15:0] data;
    bit          changed;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    bit          changed;
  } frame_t;

  frame_t     frameQ[$];
  logic [7:0] errQ[$];
  int         checks = 0;
  int         fails = 0;
  int         errModel = 0;
  vec_t       scanA[4];
  vec_t       scanB[4];
  vec_t       scanC[3];
  vec_t       scanD[4];

  seg_monitor #(.SETTLE(4)) dut (
    .clk(clk),
    .rst(rst),
    .anodes(anodes),
    .segments(segments),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_changed(data_changed),
    .err_seg(err_seg),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every output pulse against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        if (frameQ.size() == 0) begin
          check("unexpected_data_valid", 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = frameQ.pop_front();
          check("data_out", {16'd0, data_out}, {16'd0, f.data});
          check("data_changed", {31'd0, data_changed}, {31'd0, f.changed});
        end
      end else if (data_changed) begin
        check("changed_without_valid", 32'd1, 32'd0);
      end
      if (err_seg) begin
        if (errQ.size() == 0) begin
          check("unexpected_err_seg", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          e = errQ.pop_front();
          check("err_cnt_at_pulse", {24'd0, err_cnt}, {24'd0, e});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int hold);
    anodes   = an;
    segments = seg;
    repeat (hold) @(negedge clk);
  endtask

  task automatic runVec(input vec_t v);
    if (v.frame) begin
      frame_t f;
      f.data    = v.data;
      f.changed = v.changed;
      frameQ.push_back(f);
    end
    applyStimulus(v.an, v.seg, v.hold);
  endtask

  task automatic expectErr();
    if (errModel < 255) errModel++;
    errQ.push_back(8'(errModel));
  endtask

  // Wait (bounded) for all queued pulses to arrive, then confirm none remain.
  task automatic checkOutput(input string name);
    int n = 0;
    while ((frameQ.size() != 0 || errQ.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_frames_pending"}, frameQ.size(), 0);
    check({name, "_errs_pending"}, errQ.size(), 0);
  endtask

  initial begin
    scanA[0] = '{4'b0001, 7'h6D, 10, 0, 16'h0, 0};
    scanA[1] = '{4'b0010, 7'h4F, 10, 0, 16'h0, 0};
    scanA[2] = '{4'b0100, 7'h5B, 10, 0, 16'h0, 0};
    scanA[3] = '{4'b1000, 7'h06, 10, 1, 16'h1235, 1};
    scanB    = scanA;
    scanB[3].changed = 0;
    scanC[0] = '{4'b0001, 7'h3F, 10, 0, 16'h0, 0};
    scanC[1] = '{4'b0010, 7'h06, 10, 0, 16'h0, 0};
    scanC[2] = '{4'b0100, 7'h5B, 10, 0, 16'h0, 0};
    scanD[0] = '{4'b0001, 7'h5E, 10, 0, 16'h0, 0};
    scanD[1] = '{4'b0010, 7'h39, 10, 0, 16'h0, 0};
    scanD[2] = '{4'b0100, 7'h7C, 10, 0, 16'h0, 0};
    scanD[3] = '{4'b1000, 7'h77, 10, 1, 16'hABCD, 1};

    rst = 1'b1;
    anodes = 4'b0;
    segments = 7'h0;
    repeat (3) @(negedge clk);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_data_changed", {31'd0, data_changed}, 32'd0);
    check("rst_err_seg", {31'd0, err_seg}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_seen", {28'd0, dut.seen}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] first scan 1235");
    for (int i = 0; i < 4; i++) runVec(scanA[i]);
    applyStimulus(4'b0000, 7'h0, 4);
    checkOutput("scan1");

    $display("[TB] repeated scan 1235");
    for (int i = 0; i < 4; i++) runVec(scanB[i]);
    applyStimulus(4'b0000, 7'h0, 4);
    checkOutput("scan2");
    check("scan2_data_out", {16'd0, data_out}, 32'h1235);

    $display("[TB] toggling segments never settle");
    for (int i = 0; i < 8; i++) applyStimulus(4'b0001, (i % 2 == 0) ? 7'h6D : 7'h7D, 2);
    applyStimulus(4'b0000, 7'h0, 4);
    check("toggle_seen", {28'd0, dut.seen}, 32'd0);
    checkOutput("toggle");

    $display("[TB] invalid pattern then valid retry");
    applyStimulus(4'b0001, 7'h3F, 10);
    applyStimulus(4'b0010, 7'h06, 10);
    expectErr();
    applyStimulus(4'b0100, 7'h7E, 5);
    applyStimulus(4'b0000, 7'h0, 4);
    check("bad_seen", {28'd0, dut.seen}, 32'h3);
    check("bad_err_cnt", {24'd0, err_cnt}, 32'd1);
    applyStimulus(4'b0100, 7'h5B, 10);
    frameQ.push_back('{16'h4210, 1'b1});
    applyStimulus(4'b1000, 7'h66, 10);
    applyStimulus(4'b0000, 7'h0, 4);
    checkOutput("retry");

    $display("[TB] multi-hot anodes mid-scan");
    applyStimulus(4'b0001, 7'h6D, 10);
    applyStimulus(4'b0010, 7'h7D, 10);
    applyStimulus(4'b0011, 7'h07, 20);
    check("multihot_seen", {28'd0, dut.seen}, 32'h3);
    applyStimulus(4'b0100, 7'h07, 10);
    frameQ.push_back('{16'h8765, 1'b1});
    applyStimulus(4'b1000, 7'h7F, 10);
    applyStimulus(4'b0000, 7'h0, 4);
    checkOutput("multihot");

    $display("[TB] reset during partial frame");
    for (int i = 0; i < 3; i++) runVec(scanC[i]);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_data_out", {16'd0, data_out}, 32'd0);
    check("midrst_seen", {28'd0, dut.seen}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    errModel = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) runVec(scanD[i]);
    applyStimulus(4'b0000, 7'h0, 4);
    checkOutput("abcd");
    check("abcd_data_out", {16'd0, data_out}, 32'hABCD);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 258; i++) begin
      expectErr();
      applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0010, 7'h00, 5);
    end
    applyStimulus(4'b0000, 7'h0, 4);
    checkOutput("saturate");
    check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat_data_out", {16'd0, data_out}, 32'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_monitor.md
SEG_MONITOR -- requirements
Module: seg_monitor

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning the number of consecutive clk cycles a digit must hold stable before capture (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port anodes, input, 4, one-hot digit select from the display driver, asynchronous to clk.
REQ-005 SHALL have port segments, input, 7, active-high {g,f,e,d,c,b,a} pattern, asynchronous to clk.
REQ-006 SHALL have port data_out, output, 16, the last fully reconstructed display value.
REQ-007 SHALL have port data_valid, output, 1, a 1-cycle pulse when data_out is updated.
REQ-008 SHALL have port data_changed, output, 1, a 1-cycle pulse coincident with data_valid when the new value differs from the previous data_out.
REQ-009 SHALL have port err_seg, output, 1, a 1-cycle pulse when a stable digit carries a pattern outside the hex table.
REQ-010 SHALL have port err_cnt, output, 8, a saturating count of err_seg pulses.

Function
REQ-011 SHALL pass anodes and segments through a 2-flop synchroniser before any use; all latencies below count from the synchronised signals.
REQ-012 SHALL map anodes[k] active to nibble k: data_out[4k+3:4k].
REQ-013 SHALL decode patterns 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 to values 0..F respectively; any other pattern is invalid.
REQ-014 SHALL implement FSM states WAIT, COUNT, HELD.
REQ-015 WAIT: if anodes is one-hot, SHALL load the stability counter with 1, register {anodes,segments} and enter COUNT; otherwise it stays in WAIT.
REQ-016 COUNT: if {anodes,segments} equals the registered value, SHALL increment the counter; otherwise it returns to WAIT on the next cycle, discarding the digit.
REQ-017 COUNT: when the counter reaches SETTLE, SHALL accept the digit and enter HELD.
REQ-018 On a valid accepted digit, SHALL write the decoded nibble to shadow[k] and set seen[k]; a repeat of an already-seen k overwrites shadow[k].
REQ-019 On an invalid accepted digit, SHALL pulse err_seg, increment err_cnt (saturating at 255), and leave shadow and seen unchanged.
REQ-020 HELD: SHALL perform no recapture until {anodes,segments} differs from the registered value, then return to WAIT.
REQ-021 Non-one-hot anodes (0000 or more than one bit) in any state SHALL force WAIT and clear the counter.
REQ-022 When seen becomes 4'b1111, on the next cycle SHALL load data_out from shadow, pulse data_valid, pulse data_changed if the value differs, and clear seen.
REQ-023 An equal value SHALL still pulse data_valid, with data_changed held at 0.
REQ-024 Acceptance latency: a digit stable from cycle t (synchronised) SHALL be accepted at edge t+SETTLE-1; data_valid follows the fourth distinct accept by 1 cycle.
REQ-025 If a capture and frame completion coincide, frame completion SHALL use shadow including that capture, and seen SHALL restart empty.

Reset
REQ-026 While rst is high, SHALL hold data_out=0, data_valid=0, data_changed=0, err_seg=0, err_cnt=0, seen=0, shadow=0, counter=0, synchronisers=0 and state WAIT.
REQ-027 A partial frame interrupted by rst SHALL be discarded; capture after release restarts from WAIT with seen empty.

Verification
REQ-028 Drive the scan 0001:6D, 0010:4F, 0100:5B, 1000:06 with each held 10 cycles (SETTLE=4) -> data_valid pulses once, data_out=16'h1235, data_changed=1.
REQ-029 Repeat the same 4-digit scan -> data_valid=1, data_changed=0, data_out=16'h1235.
REQ-030 Hold 0001 with segments toggling every 2 cycles -> no capture, seen=0, no pulses.
REQ-031 Hold anode 0100 stable with pattern 7F-invalid 0x7E for 5 cycles -> a single err_seg pulse, err_cnt=1, seen[2]=0; a frame completes only after a valid retry.
REQ-032 Drive anodes=0011 for 20 cycles mid-scan -> state stays WAIT, no capture, seen unchanged.
REQ-033 Assert rst after 3 digits captured, release, then scan 4 digits of 16'hABCD -> exactly one data_valid with data_out=16'hABCD.
